// File: rtl/pipe_pkg.sv
// Shared types and widths for the elastic pipeline stage register.
package pipe_pkg;

  localparam int PIPE_OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle between two pipeline stages plus flush and occupancy.
interface pipe_skid_reg_if #(
  parameter int WIDTH = 32
);
  import pipe_pkg::*;

  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [PIPE_OCC_W-1:0] occupancy;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

endinterface

// File: rtl/pipe_data_reg.sv
// WIDTH-bit payload register with load enable and asynchronous reset to RESET_VALUE.
module pipe_data_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= RESET_VALUE;
    else if (load) q <= d;
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage register with valid/ready handshake and synchronous flush.
// Define PIPE_SKID_EN for the two-entry skid buffer with a registered in_ready.
//
// state | meaning
// EMPTY | no entry held, out_valid low
// BUSY  | main register holds the head entry
// FULL  | main holds head, skid holds the next entry (PIPE_SKID_EN only)
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  pipe_skid_reg_if.slave bus
);

  pipe_state_t      state, state_nxt;
  logic             in_fire, out_fire;
  logic             main_load;
  logic [WIDTH-1:0] main_d;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;

`ifdef PIPE_SKID_EN
  logic             skid_load;
  logic             main_from_skid;
  logic [WIDTH-1:0] skid_q;
  logic             in_ready_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    main_load = 1'b0;
`ifdef PIPE_SKID_EN
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
`endif
    case (state)
      EMPTY: begin
        if (in_fire) begin
          main_load = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
`ifdef PIPE_SKID_EN
        end else if (in_fire) begin
          skid_load = 1'b1;
          state_nxt = FULL;
`endif
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
`ifdef PIPE_SKID_EN
      FULL: begin
        if (bus.out_ready) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_nxt      = BUSY;
        end
      end
`endif
      default: state_nxt = EMPTY;
    endcase
    // Squash wins; data registers keep their contents and are simply marked invalid.
    if (bus.flush) begin
      state_nxt = EMPTY;
      main_load = 1'b0;
`ifdef PIPE_SKID_EN
      skid_load = 1'b0;
`endif
    end
  end

`ifdef PIPE_SKID_EN
  pipe_data_reg #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (skid_load),
    .d    (bus.in_data),
    .q    (skid_q)
  );

  assign main_d = main_from_skid ? skid_q : bus.in_data;

  // Registered ready: looks one state ahead so it is already low on entry to FULL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_ready_q <= 1'b1;
    else     in_ready_q <= (state_nxt != FULL);
  end

  assign bus.in_ready = in_ready_q;
`else
  assign main_d       = bus.in_data;
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
`endif

  pipe_data_reg #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (main_load),
    .d    (main_d),
    .q    (bus.out_data)
  );

  assign bus.out_valid = (state != EMPTY);
  assign bus.occupancy = (state == FULL) ? PIPE_OCC_W'(2) :
                         (state == BUSY) ? PIPE_OCC_W'(1) : PIPE_OCC_W'(0);

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg against a queue-based model of the stage.
module tb_pipe_skid_reg;

  localparam int          W  = 32;
  localparam logic [W-1:0] RV = 32'hA5A5_0F0F;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_skid_reg_if #(.WIDTH(W)) bus ();

  pipe_skid_reg #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int errors  = 0;
  logic [W-1:0] q[$];

  function automatic bit exp_ready();
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || bus.out_ready;
  endfunction

  function automatic int exp_occ();
    return q.size();
  endfunction

  task automatic drive(input bit v, input logic [W-1:0] d, input bit r, input bit f);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    bus.flush     = f;
    #1;
  endtask

  // Advances one clock edge and updates the model from the inputs seen at that edge.
  task automatic tick();
    bit in_f, out_f;
    in_f  = bus.in_valid && exp_ready();
    out_f = (q.size() != 0) && bus.out_ready;
    @(posedge clk);
    if (out_f) void'(q.pop_front());
    if (bus.flush) q.delete();
    else if (in_f) q.push_back(bus.in_data);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(0, '0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    #1;
    vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", bus.in_ready); end
    vectors++; if (bus.out_data !== RV) begin errors++; $display("FAIL reset out_data: got %h want %h", bus.out_data, RV); end
    vectors++; if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL reset occupancy: got %0d want 0", bus.occupancy); end
  endtask

  task automatic test_stream();
    logic [W-1:0] pat [3];
    pat[0] = 32'h11; pat[1] = 32'h22; pat[2] = 32'h33;
    for (int i = 0; i < 4; i++) begin
      drive(i < 3, (i < 3) ? pat[i] : '0, 1, 0);
      if (i > 0) begin
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== pat[i-1]) begin
          errors++; $display("FAIL stream head %0d: got v=%b d=%h want v=1 d=%h", i, bus.out_valid, bus.out_data, pat[i-1]);
        end
        vectors++; if (bus.occupancy !== 2'd1) begin errors++; $display("FAIL stream occupancy %0d: got %0d want 1", i, bus.occupancy); end
      end
      vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream in_ready %0d: got %b want 1", i, bus.in_ready); end
      tick();
    end
    drive(0, '0, 0, 0);
    vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream drained: got out_valid %b want 0", bus.out_valid); end
  endtask

  task automatic fill_ab();
    drive(1, 32'hA, 0, 0); tick();
    drive(1, 32'hB, 0, 0); tick();
    drive(0, '0, 0, 0);
  endtask

  task automatic test_full_drain();
    fill_ab();
    vectors++; if (bus.occupancy !== 2'(CAP)) begin errors++; $display("FAIL full occupancy: got %0d want %0d", bus.occupancy, CAP); end
    vectors++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full in_ready: got %b want 0", bus.in_ready); end
    drive(0, '0, 1, 0);
    vectors++; if (bus.out_data !== 32'hA || bus.out_valid !== 1'b1) begin errors++; $display("FAIL drain first: got v=%b d=%h want v=1 d=a", bus.out_valid, bus.out_data); end
    tick();
    if (CAP == 2) begin
      vectors++; if (bus.out_data !== 32'hB || bus.out_valid !== 1'b1) begin errors++; $display("FAIL drain second: got v=%b d=%h want v=1 d=b", bus.out_valid, bus.out_data); end
      tick();
    end
    drive(0, '0, 0, 0);
    vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain empty: got out_valid %b want 0", bus.out_valid); end
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL drain in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_flush();
    fill_ab();
    drive(1, 32'hC, 0, 1);
    tick();
    drive(0, '0, 1, 0);
    vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL flush occupancy: got %0d want 0", bus.occupancy); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush leak %0d: got v=%b d=%h want v=0", i, bus.out_valid, bus.out_data); end
    end
  endtask

  task automatic test_async_reset();
    fill_ab();
    #2 rst = 1'b1;
    #1;
    q.delete();
    vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_data !== RV) begin errors++; $display("FAIL arst out_data: got %h want %h", bus.out_data, RV); end
    vectors++; if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL arst occupancy: got %0d want 0", bus.occupancy); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL arst in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_random();
    int max_occ = 0;
    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(99) < 70, $urandom, $urandom_range(99) < 55, $urandom_range(99) < 2);
      vectors++; if (bus.out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rand out_valid @%0d: got %b want %b", i, bus.out_valid, q.size() != 0); end
      vectors++; if (bus.occupancy !== 2'(exp_occ())) begin errors++; $display("FAIL rand occupancy @%0d: got %0d want %0d", i, bus.occupancy, exp_occ()); end
      vectors++; if (bus.in_ready !== exp_ready()) begin errors++; $display("FAIL rand in_ready @%0d: got %b want %b", i, bus.in_ready, exp_ready()); end
      if (q.size() != 0) begin
        vectors++; if (bus.out_data !== q[0]) begin errors++; $display("FAIL rand out_data @%0d: got %h want %h", i, bus.out_data, q[0]); end
      end
      if (int'(bus.occupancy) > max_occ) max_occ = int'(bus.occupancy);
      tick();
    end
    vectors++; if (max_occ > CAP) begin errors++; $display("FAIL rand max occupancy: got %0d want <= %0d", max_occ, CAP); end
  endtask

  initial begin
    drive(0, '0, 0, 0);
    test_reset();
    test_stream();
    test_full_drain();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
